// File: rtl/reg_alu_pkg.sv
// Shared ALU opcodes, sequencer state encoding and the fixed legacy decode table.
package reg_alu_pkg;

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_AND   = 4'd2;
    localparam logic [3:0] ALU_OR    = 4'd3;
    localparam logic [3:0] ALU_XOR   = 4'd4;
    localparam logic [3:0] ALU_NOR   = 4'd5;
    localparam logic [3:0] ALU_SLL   = 4'd6;
    localparam logic [3:0] ALU_SRL   = 4'd7;
    localparam logic [3:0] ALU_SRA   = 4'd8;
    localparam logic [3:0] ALU_SLT   = 4'd9;
    localparam logic [3:0] ALU_SLTU  = 4'd10;
    localparam logic [3:0] ALU_PASSB = 4'd11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        EX   = 2'd2,
        WB   = 2'd3
    } state_t;

    // Legacy register fields are 3 bits wide; the top zero-extends them to AW.
    typedef struct packed {
        logic [3:0] aluop;
        logic [2:0] dst;
        logic [2:0] src1;
        logic [2:0] src2;
    } legacy_dec_t;

    function automatic legacy_dec_t legacy_decode(input logic [2:0] op);
        legacy_dec_t d;
        case (op)
            3'd0:    d = '{aluop: ALU_ADD,   dst: 3'd1, src1: 3'd2, src2: 3'd3};
            3'd1:    d = '{aluop: ALU_SUB,   dst: 3'd4, src1: 3'd1, src2: 3'd5};
            3'd2:    d = '{aluop: ALU_SLTU,  dst: 3'd2, src1: 3'd1, src2: 3'd2};
            3'd3:    d = '{aluop: ALU_PASSB, dst: 3'd7, src1: 3'd1, src2: 3'd2};
            3'd4:    d = '{aluop: ALU_AND,   dst: 3'd6, src1: 3'd1, src2: 3'd2};
            3'd5:    d = '{aluop: ALU_XOR,   dst: 3'd1, src1: 3'd1, src2: 3'd2};
            3'd6:    d = '{aluop: ALU_ADD,   dst: 3'd3, src1: 3'd2, src2: 3'd0};
            default: d = '{aluop: ALU_ADD,   dst: 3'd6, src1: 3'd0, src2: 3'd0};
        endcase
        return d;
    endfunction

endpackage

// File: rtl/reg_alu_sequencer_alu.sv
// Combinational ALU: wraps mod 2^DATA_W, no carry out; reserved ops pass A.
module rs_alu
    import reg_alu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [3:0]        aluop,
    output logic [DATA_W-1:0] y
);

    localparam int AW_S = $clog2(DATA_W);

    logic [AW_S-1:0] shamt;
    assign shamt = b[AW_S-1:0];

    // Result select by opcode.
    always_comb begin
        y = a;
        case (aluop)
            ALU_ADD:   y = a + b;
            ALU_SUB:   y = a - b;
            ALU_AND:   y = a & b;
            ALU_OR:    y = a | b;
            ALU_XOR:   y = a ^ b;
            ALU_NOR:   y = ~(a | b);
            ALU_SLL:   y = a << shamt;
            ALU_SRL:   y = a >> shamt;
            ALU_SRA:   y = DATA_W'($signed(a) >>> shamt);
            ALU_SLT:   y = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_SLTU:  y = {{(DATA_W-1){1'b0}}, (a < b)};
            ALU_PASSB: y = b;
            default:   y = a;
        endcase
    end

endmodule

// File: rtl/reg_alu_sequencer.sv
// Register file + ALU sequencer: IDLE -> RD -> EX -> WB, one instruction per 4 cycles.
module reg_alu_sequencer
    import reg_alu_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int NREGS     = 8,
    parameter bit LEGACY_EN = 1'b1,
    localparam int AW       = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_mode,
    input  logic [2:0]        in_op,
    input  logic [3:0]        in_aluop,
    input  logic [AW-1:0]     in_dst,
    input  logic [AW-1:0]     in_src1,
    input  logic [AW-1:0]     in_src2,
    input  logic              ld_en,
    input  logic [AW-1:0]     ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    input  logic [AW-1:0]     dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    output logic              res_valid,
    output logic [DATA_W-1:0] res_data,
    output logic [AW-1:0]     res_dst,
    output logic              res_zero,
    output logic              busy
);

    state_t state, state_nx;

    logic [NREGS-1:0][DATA_W-1:0] rf;

    logic [3:0]        op_q;
    logic [AW-1:0]     dst_q, src1_q, src2_q;
    logic [DATA_W-1:0] a_q, b_q, res_q, alu_y;
    logic [AW-1:0]     res_dst_q;
    logic              zero_q;

    legacy_dec_t       ldec;
    logic [3:0]        dec_op;
    logic [AW-1:0]     dec_dst, dec_src1, dec_src2;
    logic              accept;

    assign in_ready  = (state == IDLE) & ~ld_en;
    assign accept    = in_valid & in_ready;
    assign busy      = (state != IDLE);
    assign res_valid = (state == WB);
    assign res_data  = res_q;
    assign res_dst   = res_dst_q;
    assign res_zero  = zero_q;
    assign dbg_data  = rf[dbg_addr];

    // Instruction decode: legacy table when enabled and selected, else full fields.
    always_comb begin
        ldec     = legacy_decode(in_op);
        dec_op   = in_aluop;
        dec_dst  = in_dst;
        dec_src1 = in_src1;
        dec_src2 = in_src2;
        if (LEGACY_EN && !in_mode) begin
            dec_op   = ldec.aluop;
            dec_dst  = AW'(ldec.dst);
            dec_src1 = AW'(ldec.src1);
            dec_src2 = AW'(ldec.src2);
        end
    end

    // Next-state: fixed ring, leaving IDLE only on an accepted instruction.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = RD;
            RD:      state_nx = EX;
            EX:      state_nx = WB;
            WB:      state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    rs_alu #(.DATA_W(DATA_W)) u_alu (
        .a     (a_q),
        .b     (b_q),
        .aluop (op_q),
        .y     (alu_y)
    );

    // Datapath: latch instruction on accept, operands in RD, result in EX.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q      <= '0;
            dst_q     <= '0;
            src1_q    <= '0;
            src2_q    <= '0;
            a_q       <= '0;
            b_q       <= '0;
            res_q     <= '0;
            res_dst_q <= '0;
            zero_q    <= 1'b0;
        end else begin
            if (accept) begin
                op_q   <= dec_op;
                dst_q  <= dec_dst;
                src1_q <= dec_src1;
                src2_q <= dec_src2;
            end
            if (state == RD) begin
                a_q <= rf[src1_q];
                b_q <= rf[src2_q];
            end
            if (state == EX) begin
                res_q     <= alu_y;
                res_dst_q <= dst_q;
                zero_q    <= (alu_y == '0);
            end
        end
    end

    // Register file: host load only in IDLE, writeback at the edge ending WB.
    always_ff @(posedge clk) begin
        if (rst) begin
            rf <= '0;
        end else if (state == IDLE && ld_en) begin
            rf[ld_addr] <= ld_data;
        end else if (state == WB) begin
            rf[dst_q] <= res_q;
        end
    end

endmodule

// File: tb/tb_reg_alu_sequencer.sv
// Directed bench for reg_alu_sequencer: default 32-bit/8-reg instance plus an 8-bit/4-reg full-only one.
module tb_reg_alu_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    always #5 clk = ~clk;

    // 32-bit, 8 register, legacy enabled
    logic        in_valid = 0, in_mode = 1, ld_en = 0;
    logic [2:0]  in_op = 0, in_dst = 0, in_src1 = 0, in_src2 = 0, ld_addr = 0, dbg_addr = 0;
    logic [3:0]  in_aluop = 0;
    logic [31:0] ld_data = 0;
    logic        in_ready, res_valid, res_zero, busy;
    logic [31:0] dbg_data, res_data;
    logic [2:0]  res_dst;

    // 8-bit, 4 register, legacy disabled
    logic        e_in_valid = 0, e_in_mode = 0, e_ld_en = 0;
    logic [2:0]  e_in_op = 0;
    logic [1:0]  e_in_dst = 0, e_in_src1 = 0, e_in_src2 = 0, e_ld_addr = 0, e_dbg_addr = 0;
    logic [3:0]  e_in_aluop = 0;
    logic [7:0]  e_ld_data = 0;
    logic        e_in_ready, e_res_valid, e_res_zero, e_busy;
    logic [7:0]  e_dbg_data, e_res_data;
    logic [1:0]  e_res_dst;

    int nchecks = 0;
    int nerr    = 0;

    reg_alu_sequencer #(.DATA_W(32), .NREGS(8), .LEGACY_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
        .in_op(in_op), .in_aluop(in_aluop), .in_dst(in_dst), .in_src1(in_src1), .in_src2(in_src2),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data), .dbg_addr(dbg_addr), .dbg_data(dbg_data),
        .res_valid(res_valid), .res_data(res_data), .res_dst(res_dst), .res_zero(res_zero), .busy(busy)
    );

    reg_alu_sequencer #(.DATA_W(8), .NREGS(4), .LEGACY_EN(1'b0)) dut8 (
        .clk(clk), .rst(rst), .in_valid(e_in_valid), .in_ready(e_in_ready), .in_mode(e_in_mode),
        .in_op(e_in_op), .in_aluop(e_in_aluop), .in_dst(e_in_dst), .in_src1(e_in_src1), .in_src2(e_in_src2),
        .ld_en(e_ld_en), .ld_addr(e_ld_addr), .ld_data(e_ld_data), .dbg_addr(e_dbg_addr), .dbg_data(e_dbg_data),
        .res_valid(e_res_valid), .res_data(e_res_data), .res_dst(e_res_dst), .res_zero(e_res_zero), .busy(e_busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchecks++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [2:0] a, input logic [31:0] d);
        ld_en = 1; ld_addr = a; ld_data = d;
        tick();
        ld_en = 0;
    endtask

    task automatic fire(input logic [3:0] op, input logic [2:0] d, input logic [2:0] s1, input logic [2:0] s2);
        in_mode = 1; in_aluop = op; in_dst = d; in_src1 = s1; in_src2 = s2;
        in_valid = 1;
        tick();
        in_valid = 0;
    endtask

    task automatic fire_legacy(input logic [2:0] op);
        in_mode = 0; in_op = op;
        in_valid = 1;
        tick();
        in_valid = 0;
        in_mode = 1;
    endtask

    // Called right after the accept edge; bounded wait for the result pulse.
    task automatic wait_res(input string tag);
        int n = 0;
        while (!res_valid && n < 8) begin
            tick();
            n++;
        end
        check({tag, " latency"}, n, 2);
    endtask

    task automatic load8(input logic [1:0] a, input logic [7:0] d);
        e_ld_en = 1; e_ld_addr = a; e_ld_data = d;
        tick();
        e_ld_en = 0;
    endtask

    task automatic run8(input logic [3:0] op, input logic [1:0] d, input logic [1:0] s1, input logic [1:0] s2);
        e_in_aluop = op; e_in_dst = d; e_in_src1 = s1; e_in_src2 = s2;
        e_in_valid = 1;
        tick();
        e_in_valid = 0;
        tick();
        tick();
    endtask

    initial begin
        int acc;

        // 1: reset state
        tick(); tick();
        rst = 0;
        check("rst in_ready", in_ready, 1);
        check("rst busy", busy, 0);
        check("rst res_valid", res_valid, 0);
        check("rst res_data", res_data, 0);
        check("rst res_zero", res_zero, 0);
        for (int i = 0; i < 8; i++) begin
            dbg_addr = 3'(i);
            #1;
            check($sformatf("rst dbg R%0d", i), dbg_data, 0);
        end

        // 2: legacy op0 ADD R1 = R2 + R3
        load(3'd2, 32'd5);
        load(3'd3, 32'd7);
        fire_legacy(3'd0);
        check("op0 busy", busy, 1);
        check("op0 in_ready RD", in_ready, 0);
        wait_res("op0");
        check("op0 res_valid", res_valid, 1);
        check("op0 res_data", res_data, 32'd12);
        check("op0 res_dst", res_dst, 3'd1);
        check("op0 res_zero", res_zero, 0);
        tick();
        check("op0 pulse end", res_valid, 0);
        check("op0 idle", busy, 0);
        dbg_addr = 3'd1; #1;
        check("op0 dbg R1", dbg_data, 32'd12);

        // legacy op3: PASS_B R7 = R2
        fire_legacy(3'd3);
        wait_res("op3");
        check("op3 res_data", res_data, 32'd5);
        check("op3 res_dst", res_dst, 3'd7);
        tick();

        // 3: full SUB R4 = R3 - R2
        load(3'd3, 32'd5);
        load(3'd2, 32'd7);
        fire(4'd1, 3'd4, 3'd3, 3'd2);
        wait_res("sub1");
        check("sub1 res_data", res_data, 32'hFFFF_FFFE);
        check("sub1 res_zero", res_zero, 0);
        check("sub1 res_dst", res_dst, 3'd4);
        tick();
        load(3'd3, 32'd7);
        fire(4'd1, 3'd4, 3'd3, 3'd2);
        wait_res("sub2");
        check("sub2 res_data", res_data, 32'd0);
        check("sub2 res_zero", res_zero, 1);
        tick();
        dbg_addr = 3'd4; #1;
        check("sub2 dbg R4", dbg_data, 32'd0);

        // 4: in_valid held 10 cycles starting while the previous instruction is in RD
        fire(4'd0, 3'd5, 3'd2, 3'd3);
        in_valid = 1;
        acc = 0;
        for (int i = 0; i < 10; i++) begin
            check($sformatf("hold in_ready c%0d", i), in_ready, (i == 3 || i == 7) ? 1 : 0);
            if (in_ready) acc++;
            tick();
        end
        in_valid = 0;
        check("hold accepts", acc, 2);
        check("hold last WB", res_valid, 1);
        check("hold res_data", res_data, 32'd14);
        tick();
        check("hold idle", busy, 0);
        dbg_addr = 3'd5; #1;
        check("hold dbg R5", dbg_data, 32'd14);

        // 5: ld_en wins over in_valid; instruction then sees the loaded value
        ld_en = 1; ld_addr = 3'd6; ld_data = 32'h100;
        in_mode = 1; in_aluop = 4'd0; in_dst = 3'd7; in_src1 = 3'd6; in_src2 = 3'd6;
        in_valid = 1;
        #1;
        check("ld+inv in_ready", in_ready, 0);
        tick();
        ld_en = 0;
        #1;
        check("ld+inv not busy", busy, 0);
        check("ld+inv in_ready after", in_ready, 1);
        dbg_addr = 3'd6; #1;
        check("ld+inv dbg R6", dbg_data, 32'h100);
        tick();
        in_valid = 0;
        wait_res("ld+inv");
        check("ld+inv res_data", res_data, 32'h200);
        check("ld+inv res_dst", res_dst, 3'd7);
        tick();

        // 6: reset in EX aborts the instruction
        fire(4'd0, 3'd1, 3'd5, 3'd5);
        tick();
        rst = 1;
        tick();
        rst = 0;
        check("abort busy", busy, 0);
        check("abort in_ready", in_ready, 1);
        check("abort res_valid", res_valid, 0);
        check("abort res_data", res_data, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("abort no pulse c%0d", i), res_valid, 0);
        end
        for (int i = 0; i < 8; i++) begin
            dbg_addr = 3'(i);
            #1;
            check($sformatf("abort dbg R%0d", i), dbg_data, 0);
        end

        // 7: 8-bit, 4 register, full decode regardless of in_mode
        load8(2'd1, 8'hF0);
        load8(2'd2, 8'h20);
        run8(4'd0, 2'd3, 2'd1, 2'd2);
        check("w8 add valid", e_res_valid, 1);
        check("w8 add data", e_res_data, 8'h10);
        check("w8 add dst", e_res_dst, 2'd3);
        tick();
        e_dbg_addr = 2'd3; #1;
        check("w8 dbg R3", e_dbg_data, 8'h10);
        load8(2'd0, 8'h80);
        load8(2'd1, 8'h03);
        run8(4'd8, 2'd2, 2'd0, 2'd1);
        check("w8 sra valid", e_res_valid, 1);
        check("w8 sra data", e_res_data, 8'hF0);
        tick();
        check("w8 idle", e_busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
